operand_b_sel_unit: RTL and testbench

- Next-generation operand-B selector for the ID stage of the RSA-decryption ASIP; replaces the plain 2-way rb/rf mux.
- Selects operand B from one of four sources, with tag-compared forwarding from NFWD downstream pipeline stages.
- Detects load-use hazards and raises a stall request.
- Registers the selected operand into a 1-entry valid/ready output stage that feeds EX.

---
 rtl/operand_b_sel_unit.sv | 145 ++++++++++++++
 tb/tb_operand_b_sel_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_sel_unit.sv
// -----------------------------------------------------------------------------
// operand_b_sel_unit
//
// Operand-B selector for the ID stage of the RSA-decryption ASIP. Picks operand
// B from rb, rf, constant zero or the last captured operand. When rb is chosen,
// a result pending in a downstream stage (EX .. WB) is forwarded in its place,
// with the youngest stage winning. A forwarding hit on a stage whose result is
// not ready yet (a load in flight) raises stall_req. The chosen operand is held
// in a one-entry valid/ready stage that feeds EX.
//
// Optional feature, enabled by defining OPB_SEL_STALL_CNT_EN:
//   a saturating stall counter (stall_cnt) with a synchronous clear (stall_cnt_clr).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   rb, rb_addr   register-file B read data and the register it came from
//   rf            alternate source (immediate / F register)
//   src_sel       0=rb (forwardable), 1=rf, 2=zero, 3=re-issue last operand
//   in_valid      ID presents an operand request
//   in_ready      request accepted this cycle
//   fwd_valid     stage i holds a register-writing instruction
//   fwd_ready     stage i result is available
//   fwd_addr      stage i destination at [i*ADDR_W +: ADDR_W]
//   fwd_data      stage i result at [i*N +: N]
//   flush         squash the ID/EX operand
//   out_valid     operand_b valid for EX
//   out_ready     EX consumes operand_b
//   operand_b     registered selected operand
//   stall_req     load-use hazard stall request
//   stall_cnt     (optional) cycles spent with stall_req high, saturating
//   stall_cnt_clr (optional) synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module operand_b_sel_unit #(
  parameter int N      = 32,
  parameter int ADDR_W = 4,
  parameter int NFWD   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           rb,
  input  logic [N-1:0]           rf,
  input  logic [1:0]             src_sel,
  input  logic [ADDR_W-1:0]      rb_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_ready,
  input  logic [NFWD*ADDR_W-1:0] fwd_addr,
  input  logic [NFWD*N-1:0]      fwd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           operand_b,
  output logic                   stall_req
`ifdef OPB_SEL_STALL_CNT_EN
  ,
  input  logic                   stall_cnt_clr,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} stage_state_t;

  stage_state_t state;
  logic [N-1:0] last_operand;
  logic [N-1:0] sel_value;
  logic [N-1:0] match_data;
  logic         match_any;
  logic         match_ready;
  logic         hazard;
  logic         capture;

  // Forwarding lookup. The loop walks from the oldest stage towards EX so the
  // youngest matching stage overwrites any older one; an older stage that is
  // ready can therefore never hide a pending load in a younger stage.
  // Register 0 is hard-wired and never forwards.
  always_comb begin
    match_any   = 1'b0;
    match_ready = 1'b0;
    match_data  = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if ((src_sel == 2'd0) && (rb_addr != '0) && fwd_valid[i] &&
          (fwd_addr[i*ADDR_W +: ADDR_W] == rb_addr)) begin
        match_any   = 1'b1;
        match_ready = fwd_ready[i];
        match_data  = fwd_data[i*N +: N];
      end
    end
  end

  // Source mux; the forwarded value replaces rb only on a hit.
  always_comb begin
    case (src_sel)
      2'd0:    sel_value = match_any ? match_data : rb;
      2'd1:    sel_value = rf;
      2'd2:    sel_value = '0;
      default: sel_value = last_operand;
    endcase
  end

  // The hazard only matters when ID actually wants an operand.
  assign hazard    = in_valid && match_any && !match_ready;
  assign stall_req = hazard;
  assign out_valid = (state == FULL);
  assign in_ready  = !hazard && (!out_valid || out_ready) && !flush;
  assign capture   = in_valid && in_ready;

  // Output stage. flush wins over everything and leaves the last-operand
  // register alone so a later re-issue still sees the last real capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      operand_b    <= '0;
      last_operand <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (capture) begin
      state        <= FULL;
      operand_b    <= sel_value;
      last_operand <= sel_value;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

`ifdef OPB_SEL_STALL_CNT_EN
  // Stall counter: clear beats increment, and it sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_req && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // CNT_W only sizes the optional counter; it has no effect in this build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_operand_b_sel_unit.sv
// -----------------------------------------------------------------------------
// tb_operand_b_sel_unit
//
// Self-checking bench for operand_b_sel_unit. A behavioural model of the
// selector and output stage is stepped alongside the DUT and compared every
// cycle; directed scenarios add literal expectations, then randomized traffic
// runs against the same model. Define OPB_SEL_STALL_CNT_EN to also cover the
// stall counter (built with CNT_W=2).
// -----------------------------------------------------------------------------
module tb_operand_b_sel_unit;

  localparam int N      = 32;
  localparam int ADDR_W = 4;
  localparam int NFWD   = 3;
`ifdef OPB_SEL_STALL_CNT_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 16;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           rb = '0;
  logic [N-1:0]           rf = '0;
  logic [1:0]             src_sel = '0;
  logic [ADDR_W-1:0]      rb_addr = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [NFWD-1:0]        fwd_valid = '0;
  logic [NFWD-1:0]        fwd_ready = '0;
  logic [NFWD*ADDR_W-1:0] fwd_addr = '0;
  logic [NFWD*N-1:0]      fwd_data = '0;
  logic                   flush = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [N-1:0]           operand_b;
  logic                   stall_req;
`ifdef OPB_SEL_STALL_CNT_EN
  logic                   stall_cnt_clr = 1'b0;
  logic [CNT_W-1:0]       stall_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model state: output stage contents, last captured operand, stall count.
  logic         m_valid;
  logic [N-1:0] m_opb;
  logic [N-1:0] m_last;
  int           m_cnt;

  operand_b_sel_unit #(.N(N), .ADDR_W(ADDR_W), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rb(rb), .rf(rf), .src_sel(src_sel),
    .rb_addr(rb_addr), .in_valid(in_valid), .in_ready(in_ready),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .operand_b(operand_b), .stall_req(stall_req)
`ifdef OPB_SEL_STALL_CNT_EN
    , .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One comparison: counts it, reports a miscompare with both values.
  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives every request-side input; stage fields are given per stage.
  task automatic applyStimulus(input logic [1:0] s, input logic [N-1:0] rbv,
                               input logic [ADDR_W-1:0] ra, input logic [N-1:0] rfv,
                               input logic iv, input logic ordy, input logic fl,
                               input logic [NFWD-1:0] fv, input logic [NFWD-1:0] fr,
                               input logic [NFWD*ADDR_W-1:0] fa,
                               input logic [NFWD*N-1:0] fd);
    src_sel = s; rb = rbv; rb_addr = ra; rf = rfv; in_valid = iv;
    out_ready = ordy; flush = fl; fwd_valid = fv; fwd_ready = fr;
    fwd_addr = fa; fwd_data = fd;
  endtask

  // What the selector must produce for the current inputs: scan the stages
  // from EX outward and take the first one writing rb_addr (never for r0).
  task automatic modelEval(output logic hz, output logic [N-1:0] val);
    int hit;
    hit = -1;
    if (src_sel == 2'd0 && rb_addr != 0)
      for (int i = 0; i < NFWD; i++)
        if (hit < 0 && fwd_valid[i] && fwd_addr[i*ADDR_W +: ADDR_W] == rb_addr)
          hit = i;
    hz = in_valid && (hit >= 0) && !fwd_ready[hit];
    case (src_sel)
      2'd0:    val = (hit >= 0) ? fwd_data[hit*N +: N] : rb;
      2'd1:    val = rf;
      2'd2:    val = '0;
      default: val = m_last;
    endcase
  endtask

  task automatic modelReset();
    m_valid = 1'b0; m_opb = '0; m_last = '0; m_cnt = 0;
  endtask

  // Compare all outputs against the model, then advance one clock and update
  // the model with what that edge must have done. Called at a falling edge.
  task automatic stepCycle();
    logic         hz;
    logic [N-1:0] val;
    logic         exp_ready;
    #1;
    modelEval(hz, val);
    exp_ready = !hz && (!m_valid || out_ready) && !flush;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    checkOutput("operand_b", operand_b, m_opb);
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    checkOutput("stall_req", {31'd0, stall_req}, {31'd0, hz});
`ifdef OPB_SEL_STALL_CNT_EN
    checkOutput("stall_cnt", N'(stall_cnt), N'(m_cnt));
`endif
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (in_valid && exp_ready) begin
      m_valid = 1'b1; m_opb = val; m_last = val;
    end else if (out_ready) m_valid = 1'b0;
`ifdef OPB_SEL_STALL_CNT_EN
    if (stall_cnt_clr) m_cnt = 0;
    else if (hz && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
    @(negedge clk);
  endtask

  initial begin
    modelReset();
    #12;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_operand_b", operand_b, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_stall_req", {31'd0, stall_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain rb capture with one-cycle latency.
    applyStimulus(2'd0, 32'h1234, 4'd5, '0, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, '0, '0);
    stepCycle();
    checkOutput("rb_capture_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("rb_capture_data", operand_b, 32'h0000_1234);

    // Two stages target r7: EX wins, then WB once EX drops out.
    applyStimulus(2'd0, 32'h1111, 4'd7, '0, 1'b1, 1'b1, 1'b0, 3'b101, 3'b111,
                  {4'd7, 4'd3, 4'd7}, {32'hCCCC, 32'hBBBB, 32'hAAAA});
    stepCycle();
    checkOutput("fwd_priority", operand_b, 32'h0000_AAAA);
    fwd_valid = 3'b100;
    stepCycle();
    checkOutput("fwd_wb", operand_b, 32'h0000_CCCC);

    // Load-use hazard in EX, then the load result arrives.
    applyStimulus(2'd0, 32'h1111, 4'd7, '0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000,
                  {4'd0, 4'd0, 4'd7}, {32'h0, 32'h0, 32'h55});
    #1;
    checkOutput("hazard_stall", {31'd0, stall_req}, 32'd1);
    checkOutput("hazard_in_ready", {31'd0, in_ready}, 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("hazard_no_capture", {31'd0, out_valid}, 32'd0);
    fwd_ready = 3'b001;
    #1;
    checkOutput("hazard_cleared", {31'd0, stall_req}, 32'd0);
    stepCycle();
    checkOutput("load_forward", operand_b, 32'h0000_0055);

    // r0 never forwards; then zero, rf, and re-issue of the last capture.
    applyStimulus(2'd0, 32'hBEEF, 4'd0, 32'h77, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000,
                  {4'd0, 4'd0, 4'd0}, {32'h0, 32'h0, 32'hFF});
    #1;
    checkOutput("r0_no_stall", {31'd0, stall_req}, 32'd0);
    stepCycle();
    checkOutput("r0_reads_rb", operand_b, 32'h0000_BEEF);
    src_sel = 2'd2;
    stepCycle();
    checkOutput("zero_source", operand_b, 32'd0);
    src_sel = 2'd1;
    stepCycle();
    src_sel = 2'd3;
    stepCycle();
    checkOutput("hold_source", operand_b, 32'h0000_0077);

    // Back-pressure holds the operand, flush empties the stage.
    applyStimulus(2'd1, '0, 4'd0, 32'h99, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, '0, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
      stepCycle();
      checkOutput("bp_stable", operand_b, 32'h0000_0077);
    end
    flush = 1'b1;
    stepCycle();
    checkOutput("flush_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_no_capture", operand_b, 32'h0000_0077);
    flush = 1'b0;
    stepCycle();
    checkOutput("after_flush_capture", operand_b, 32'h0000_0099);

    // Reset in the middle of traffic drops the operand and the history.
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_operand", operand_b, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'd3, 32'h5, 4'd1, 32'h6, 1'b1, 1'b1, 1'b0, 3'b000, 3'b111, '0, '0);
    stepCycle();
    checkOutput("hold_after_reset", operand_b, 32'd0);
    checkOutput("hold_after_reset_v", {31'd0, out_valid}, 32'd1);

`ifdef OPB_SEL_STALL_CNT_EN
    // Five stalled cycles saturate a 2-bit counter; the clear wins.
    applyStimulus(2'd0, '0, 4'd7, '0, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000,
                  {4'd0, 4'd0, 4'd7}, '0);
    repeat (5) stepCycle();
    checkOutput("cnt_saturate", N'(stall_cnt), 32'd3);
    stall_cnt_clr = 1'b1;
    stepCycle();
    checkOutput("cnt_clear", N'(stall_cnt), 32'd0);
    stall_cnt_clr = 1'b0;
`endif

    // Random traffic over a small address space so stages collide often.
    for (int c = 0; c < 600; c++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 3)),
                    $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0), 3'($urandom),
                    {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0)},
                    {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 3))},
                    {$urandom, $urandom, $urandom});
`ifdef OPB_SEL_STALL_CNT_EN
      stall_cnt_clr = ($urandom_range(0, 20) == 0);
`endif
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
